// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: detects ECALL/EBREAK/MRET and timer interrupts, walks the
// mepc/mstatus/mcause write sequence one CSR per cycle, then redirects the PC for one cycle.
module csr_trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        int_flag_i,
   input  logic [31:0] csr_mtvec_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mstatus_i,
   input  logic [31:0] csr_mie_i,
   output logic        csr_wen_o,
   output logic [31:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic        hold_flag_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o
);

   localparam logic [31:0] InstEcall  = 32'h0000_0073;
   localparam logic [31:0] InstEbreak = 32'h0010_0073;
   localparam logic [31:0] InstMret   = 32'h3020_0073;

   localparam logic [31:0] CsrMstatus = 32'h0000_0300;
   localparam logic [31:0] CsrMepc    = 32'h0000_0341;
   localparam logic [31:0] CsrMcause  = 32'h0000_0342;

   localparam logic [31:0] CauseEcall  = 32'd11;
   localparam logic [31:0] CauseEbreak = 32'd3;
   localparam logic [31:0] CauseTimer  = 32'h8000_0007;

   typedef enum logic [2:0] {
      StIdle,
      StWMepc,
      StWMstatus,
      StWMcause,
      StAssert,
      StWMret,
      StMAssert
   } state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [31:0] r_cause;
   logic [31:0] r_epc;
   logic [31:0] r_mstatus;

   logic        w_is_ecall;
   logic        w_is_ebreak;
   logic        w_is_mret;
   logic        w_sync_trap;
   logic        w_int_take;
   logic        w_trap_start;
   logic [31:0] w_cause;
   logic [31:0] w_epc;
   logic        w_unused_bits;

   assign w_is_ecall  = (inst_i == InstEcall);
   assign w_is_ebreak = (inst_i == InstEbreak);
   assign w_is_mret   = (inst_i == InstMret);
   assign w_sync_trap = w_is_ecall | w_is_ebreak;

   // Any decoded trap instruction beats the interrupt; the interrupt is never latched.
   assign w_int_take   = int_flag_i & csr_mstatus_i[3] & csr_mie_i[7] & ~w_sync_trap & ~w_is_mret;
   assign w_trap_start = (r_state == StIdle) & (w_sync_trap | w_int_take);

   assign w_cause = w_is_ecall  ? CauseEcall  :
                    w_is_ebreak ? CauseEbreak : CauseTimer;
   // An interrupt taken alongside a resolved branch must resume at the branch target.
   assign w_epc   = w_sync_trap ? inst_addr_i :
                    (jump_flag_i ? jump_addr_i : inst_addr_i);

   assign w_unused_bits = ^{csr_mie_i[31:8], csr_mie_i[6:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_cause   <= '0;
         r_epc     <= '0;
         r_mstatus <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_trap_start) begin
            r_cause   <= w_cause;
            r_epc     <= w_epc;
            r_mstatus <= csr_mstatus_i;
         end else if ((r_state == StIdle) && w_is_mret) begin
            r_mstatus <= csr_mstatus_i;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      csr_wen_o    = 1'b0;
      csr_waddr_o  = '0;
      csr_wdata_o  = '0;
      hold_flag_o  = 1'b0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;

      case (r_state)
         StIdle: begin
            if (w_sync_trap || w_int_take) begin
               w_state_next = StWMepc;
               hold_flag_o  = 1'b1;
            end else if (w_is_mret) begin
               w_state_next = StWMret;
               hold_flag_o  = 1'b1;
            end
         end
         StWMepc: begin
            w_state_next = StWMstatus;
            hold_flag_o  = 1'b1;
            csr_wen_o    = 1'b1;
            csr_waddr_o  = CsrMepc;
            csr_wdata_o  = r_epc;
         end
         StWMstatus: begin
            w_state_next = StWMcause;
            hold_flag_o  = 1'b1;
            csr_wen_o    = 1'b1;
            csr_waddr_o  = CsrMstatus;
            // MPIE <= MIE, MIE <= 0
            csr_wdata_o  = {r_mstatus[31:8], r_mstatus[3], r_mstatus[6:4], 1'b0, r_mstatus[2:0]};
         end
         StWMcause: begin
            w_state_next = StAssert;
            hold_flag_o  = 1'b1;
            csr_wen_o    = 1'b1;
            csr_waddr_o  = CsrMcause;
            csr_wdata_o  = r_cause;
         end
         StAssert: begin
            w_state_next = StIdle;
            hold_flag_o  = 1'b1;
            int_assert_o = 1'b1;
            int_addr_o   = csr_mtvec_i;
         end
         StWMret: begin
            w_state_next = StMAssert;
            hold_flag_o  = 1'b1;
            csr_wen_o    = 1'b1;
            csr_waddr_o  = CsrMstatus;
            // MIE <= MPIE, MPIE <= 1
            csr_wdata_o  = {r_mstatus[31:8], 1'b1, r_mstatus[6:4], r_mstatus[7], r_mstatus[2:0]};
         end
         StMAssert: begin
            w_state_next = StIdle;
            hold_flag_o  = 1'b1;
            int_assert_o = 1'b1;
            int_addr_o   = csr_mepc_i;
         end
         default: w_state_next = StIdle;
      endcase

      // Reset kills any in-flight write or redirect in the same cycle.
      if (rst) begin
         csr_wen_o    = 1'b0;
         csr_waddr_o  = '0;
         csr_wdata_o  = '0;
         hold_flag_o  = 1'b0;
         int_assert_o = 1'b0;
         int_addr_o   = '0;
      end
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: stimulus pushes the expected CSR writes and redirects,
// a negedge monitor pops and compares them whenever the DUT writes or redirects.
module tb_csr_trap_ctrl;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] inst_i;
   logic [31:0] inst_addr_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        int_flag_i;
   logic [31:0] csr_mtvec_i;
   logic [31:0] csr_mepc_i;
   logic [31:0] csr_mstatus_i;
   logic [31:0] csr_mie_i;
   logic        csr_wen_o;
   logic [31:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic        hold_flag_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;

   typedef struct {
      bit          is_int;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  hold_cnt = 0;

   csr_trap_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .inst_i       (inst_i),
      .inst_addr_i  (inst_addr_i),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .int_flag_i   (int_flag_i),
      .csr_mtvec_i  (csr_mtvec_i),
      .csr_mepc_i   (csr_mepc_i),
      .csr_mstatus_i(csr_mstatus_i),
      .csr_mie_i    (csr_mie_i),
      .csr_wen_o    (csr_wen_o),
      .csr_waddr_o  (csr_waddr_o),
      .csr_wdata_o  (csr_wdata_o),
      .hold_flag_o  (hold_flag_o),
      .int_assert_o (int_assert_o),
      .int_addr_o   (int_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every write or redirect the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      ev_t e;
      if (hold_flag_o) hold_cnt++;
      if (csr_wen_o || int_assert_o) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output wen=%0b waddr=%h wdata=%h assert=%0b addr=%h",
                     csr_wen_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", {62'd0, csr_wen_o, int_assert_o}, {62'd0, !e.is_int, e.is_int});
            if (e.is_int) begin
               chk("int_addr", {32'd0, int_addr_o}, {32'd0, e.addr});
            end else begin
               chk("csr_waddr", {32'd0, csr_waddr_o}, {32'd0, e.addr});
               chk("csr_wdata", {32'd0, csr_wdata_o}, {32'd0, e.data});
            end
         end
      end
      if (!csr_wen_o) chk("idle_waddr_wdata_zero", {csr_waddr_o, csr_wdata_o}, 64'd0);
      if (!int_assert_o) chk("idle_int_addr_zero", {32'd0, int_addr_o}, 64'd0);
   end

   function automatic logic [31:0] pick_inst();
      case ($urandom_range(0, 5))
         0:       return ECALL;
         1:       return EBREAK;
         2:       return MRET;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic jf,
                        input logic [31:0] ja, input logic iflag, input logic [31:0] ms,
                        input logic [31:0] mie);
      inst_i        = inst;
      inst_addr_i   = pc;
      jump_flag_i   = jf;
      jump_addr_i   = ja;
      int_flag_i    = iflag;
      csr_mstatus_i = ms;
      csr_mie_i     = mie;
   endtask

   // While busy, every non-CSR input is noise and must not change the outcome.
   task automatic drive_garbage();
      drive(pick_inst(), $urandom, 1'($urandom), $urandom, 1'b1, $urandom, $urandom);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"}, {61'd0, hold_flag_o, csr_wen_o, int_assert_o}, 64'd0);
      chk({tag, "_data"}, {csr_waddr_o, csr_wdata_o}, 64'd0);
      chk({tag, "_int_addr"}, {32'd0, int_addr_o}, 64'd0);
   endtask

   task automatic push(input bit is_int, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      e.is_int = is_int;
      e.addr   = addr;
      e.data   = data;
      exp_q.push_back(e);
   endtask

   // One detection cycle followed by whatever busy cycles the reference rules imply.
   task automatic txn(input logic [31:0] inst, input logic [31:0] pc, input logic jf,
                      input logic [31:0] ja, input logic iflag, input logic [31:0] ms,
                      input logic [31:0] mie, input logic [31:0] mtvec, input logic [31:0] mepc);
      bit          ec, eb, mr, tk;
      int          ncyc, exp_hold, base;
      logic [31:0] cause, epc, ms_trap, ms_mret;
      ec = (inst == ECALL);
      eb = (inst == EBREAK);
      mr = (inst == MRET);
      tk = iflag && ms[3] && mie[7] && !ec && !eb && !mr;
      cause   = ec ? 32'd11 : (eb ? 32'd3 : 32'h8000_0007);
      epc     = (ec || eb) ? pc : (jf ? ja : pc);
      ms_trap = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
      ms_mret = (ms & ~32'h88) | (ms[7] ? 32'h08 : 32'h0) | 32'h80;
      base = 0;
      if (ec || eb || tk) begin
         push(0, 32'h341, epc);
         push(0, 32'h300, ms_trap);
         push(0, 32'h342, cause);
         push(1, mtvec, 32'd0);
         ncyc = 5;
      end else if (mr) begin
         push(0, 32'h300, ms_mret);
         push(1, mepc, 32'd0);
         ncyc = 3;
      end else begin
         ncyc = 1;
      end
      exp_hold = (ncyc == 1) ? 0 : ncyc;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            base        = hold_cnt;
            csr_mtvec_i = mtvec;
            csr_mepc_i  = mepc;
            drive(inst, pc, jf, ja, iflag, ms, mie);
         end else begin
            drive_garbage();
         end
      end
      @(negedge clk);
      #1;
      chk("hold_cycles", 64'(hold_cnt - base), 64'(exp_hold));
      chk("events_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // Reset landing in the W_MSTATUS cycle: only the mepc write may ever appear.
   task automatic reset_abort();
      push(0, 32'h341, 32'h0000_0A00);
      @(posedge clk);
      #1;
      csr_mtvec_i = 32'h0000_0800;
      csr_mepc_i  = 32'h0;
      drive(ECALL, 32'h0000_0A00, 1'b0, 32'h0, 1'b0, 32'h8, 32'h0);
      @(posedge clk);
      #1;
      drive_garbage();
      @(posedge clk);
      #1;
      drive_garbage();
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_all_zero("abort_in_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check_all_zero("abort_after_reset");
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      check_all_zero("abort_settled");
      chk("abort_events_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst         = 1'b1;
      csr_mtvec_i = 32'h0;
      csr_mepc_i  = 32'h0;
      drive(ECALL, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h80);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         drive_garbage();
         @(negedge clk);
         #1;
         check_all_zero("reset");
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check_all_zero("after_reset");

      txn(ECALL, 32'h100, 1'b0, 32'h0,   1'b0, 32'h8,  32'h0,  32'h200, 32'h0);
      txn(MRET,  32'h0,   1'b0, 32'h0,   1'b0, 32'h80, 32'h0,  32'h0,   32'h104);
      txn(NOP,   32'h50,  1'b1, 32'h300, 1'b1, 32'h8,  32'h80, 32'h400, 32'h0);
      txn(NOP,   32'h60,  1'b0, 32'h0,   1'b1, 32'h0,  32'h80, 32'h400, 32'h0);
      txn(ECALL, 32'h70,  1'b0, 32'h0,   1'b1, 32'h0,  32'h80, 32'h400, 32'h0);
      txn(NOP,   32'h74,  1'b0, 32'h0,   1'b1, 32'h0,  32'h80, 32'h400, 32'h0);
      txn(EBREAK, 32'h80, 1'b1, 32'h900, 1'b1, 32'h88, 32'h80, 32'h440, 32'h0);
      txn(NOP,   32'h84,  1'b1, 32'h123, 1'b1, 32'h8,  32'h0,  32'h400, 32'h0);
      reset_abort();

      for (int i = 0; i < 250; i++) begin
         txn(pick_inst(), $urandom, 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
             $urandom, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
